// File: rtl/mib_pkg.sv
// Shared definitions for the MIB command-bus responder and its master-side models.
// Bus width, master acknowledge window and responder FSM state encoding.
package mib_pkg;

    localparam int MIB_BUS_BITS           = 16;
    localparam int P_CMD_ACK_TIMEOUT_CLKS = 32;
    localparam int MIB_ADDR_BITS_DEF      = 24;
    localparam int MIB_DATA_BITS_DEF      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_WDATA_HI,
        ST_WDATA_LO,
        ST_REQ,
        ST_WR_ACK,
        ST_RD_HI,
        ST_RD_LO
    } mib_state_t;

endpackage

// File: rtl/mib_slave.sv
// MIB responder: decodes multiplexed bus transactions into one register-port request each.
// All outputs registered; read data returned as two beats behind slave_ack, pad driven only then.
module mib_slave
    import mib_pkg::*;
#(
    parameter int ADDR_BITS   = MIB_ADDR_BITS_DEF,
    parameter int DATA_BITS   = MIB_DATA_BITS_DEF,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mib_start,
    input  logic                    mib_rd_wr_n,
    input  logic [MIB_BUS_BITS-1:0] mib_ad_i,
    output logic [MIB_BUS_BITS-1:0] mib_ad_o,
    output logic                    mib_ad_oe,
    output logic                    mib_slave_ack,
    output logic                    reg_req,
    output logic                    reg_wr,
    output logic [ADDR_BITS-1:0]    reg_addr,
    output logic [DATA_BITS-1:0]    reg_wdata,
    input  logic [DATA_BITS-1:0]    reg_rdata,
    input  logic                    reg_ack,
    output logic                    timeout_pulse,
    output logic                    proto_err
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mib_state_t                state_q, state_d;
    logic                      wr_q, wr_d;
    logic [ADDR_BITS-1:0]      addr_q, addr_d;
    logic [DATA_BITS-1:0]      wdata_q, wdata_d;
    logic [DATA_BITS-1:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      req_q, req_d;
    logic                      ack_q, ack_d;
    logic                      oe_q, oe_d;
    logic [MIB_BUS_BITS-1:0]   ad_o_q, ad_o_d;
    logic                      to_q, to_d;
    logic                      perr_q, perr_d;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = '0;
        to_d    = 1'b0;
        perr_d  = 1'b0;

        // A start beat always wins: mid-transaction it aborts the current access.
        if (mib_start) begin
            perr_d                   = (state_q != ST_IDLE);
            wr_d                     = ~mib_rd_wr_n;
            addr_d[ADDR_BITS-1:16]   = mib_ad_i[ADDR_BITS-17:0];
            state_d                  = ST_ADDR_LO;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_ADDR_LO: begin
                    addr_d[15:0] = mib_ad_i;
                    state_d      = wr_q ? ST_WDATA_HI : ST_REQ;
                end
                ST_WDATA_HI: begin
                    wdata_d[DATA_BITS-1:MIB_BUS_BITS] = mib_ad_i;
                    state_d                           = ST_WDATA_LO;
                end
                ST_WDATA_LO: begin
                    wdata_d[MIB_BUS_BITS-1:0] = mib_ad_i;
                    state_d                   = ST_REQ;
                end
                ST_REQ: begin
                    if (reg_ack) begin
                        rdata_d = reg_rdata;
                        state_d = wr_q ? ST_WR_ACK : ST_RD_HI;
                    end else if (cnt_q == CNT_LAST) begin
                        to_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WR_ACK: state_d = ST_IDLE;
                ST_RD_HI:  state_d = ST_RD_LO;
                ST_RD_LO:  state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        req_d  = (state_d == ST_REQ);
        ack_d  = (state_d == ST_WR_ACK) || (state_d == ST_RD_HI);
        oe_d   = (state_d == ST_RD_HI) || (state_d == ST_RD_LO);
        ad_o_d = '0;
        if (state_d == ST_RD_HI) begin
            ad_o_d = rdata_d[DATA_BITS-1:MIB_BUS_BITS];
        end else if (state_d == ST_RD_LO) begin
            ad_o_d = rdata_q[MIB_BUS_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            oe_q    <= 1'b0;
            ad_o_q  <= '0;
            to_q    <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            oe_q    <= oe_d;
            ad_o_q  <= ad_o_d;
            to_q    <= to_d;
            perr_q  <= perr_d;
        end
    end

    assign reg_req       = req_q;
    assign reg_wr        = wr_q;
    assign reg_addr      = addr_q;
    assign reg_wdata     = wdata_q;
    assign mib_slave_ack = ack_q;
    assign mib_ad_oe     = oe_q;
    assign mib_ad_o      = ad_o_q;
    assign timeout_pulse = to_q;
    assign proto_err     = perr_q;

endmodule

// File: tb/tb_mib_slave.sv
// Bench for mib_slave: master BFM plus register-file responder, checked against a transaction-level model.
module tb_mib_slave;
    import mib_pkg::*;

    localparam int AW  = 24;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam int WIN = P_CMD_ACK_TIMEOUT_CLKS + 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mib_start, mib_rd_wr_n;
    logic [15:0]   mib_ad_i, mib_ad_o;
    logic          mib_ad_oe, mib_slave_ack;
    logic          reg_req, reg_wr, reg_ack;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata, reg_rdata;
    logic          timeout_pulse, proto_err;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] model_mem [logic [23:0]];
    logic [31:0] rf_mem    [logic [23:0]];

    always #5 clk = ~clk;

    mib_slave #(.ADDR_BITS(AW), .DATA_BITS(DW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mib_start(mib_start), .mib_rd_wr_n(mib_rd_wr_n),
        .mib_ad_i(mib_ad_i), .mib_ad_o(mib_ad_o), .mib_ad_oe(mib_ad_oe),
        .mib_slave_ack(mib_slave_ack),
        .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .timeout_pulse(timeout_pulse), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Power-on contents of registers never written.
    function automatic logic [31:0] dflt(input logic [23:0] a);
        return {a[7:0], ~a[15:0], a[23:16]};
    endfunction

    task automatic outputs_zero(input string pfx);
        chk({pfx, "_oe"},   64'(mib_ad_oe), 64'd0);
        chk({pfx, "_ack"},  64'(mib_slave_ack), 64'd0);
        chk({pfx, "_req"},  64'(reg_req), 64'd0);
        chk({pfx, "_ad_o"}, 64'(mib_ad_o), 64'd0);
        chk({pfx, "_misc"}, 64'({reg_wr, timeout_pulse, proto_err, reg_addr, reg_wdata}), 64'd0);
    endtask

    // One master transaction; the register side acks after dly cycles of reg_req (dly >= TO never acks).
    task automatic do_txn(input bit is_wr, input logic [23:0] a, input logic [31:0] wd,
                          input int dly, input bit fast, input int exp_perr);
        int req_cyc = 0, first_req = -1, ack_cnt = 0, ack_c = -1;
        int oe_cnt = 0, first_oe = -1, to_cnt = 0, pe_cnt = 0, cont = 0, exp_ack_c;
        logic [15:0] rd_hi = '0, rd_lo = '0;
        logic [23:0] cap_addr = '0;
        logic        cap_wr = 1'b0;
        logic [31:0] cap_wd = '0, exp_rd;
        bit          to, done = 1'b0;

        to        = (dly >= TO);
        exp_rd    = model_mem.exists(a) ? model_mem[a] : dflt(a);
        exp_ack_c = to ? -1 : ((is_wr ? 4 : 2) + dly);

        reg_ack = 1'b0;
        if (mib_ad_oe) cont++;
        mib_start   = 1'b1;
        mib_rd_wr_n = ~is_wr;
        mib_ad_i    = {8'($urandom), a[23:16]};
        @(negedge clk);
        if (proto_err) pe_cnt++;
        if (mib_ad_oe) cont++;
        mib_start = 1'b0;
        mib_ad_i  = a[15:0];
        @(negedge clk);

        for (int c = 1; c <= WIN && !done; c++) begin
            if (reg_req) begin
                req_cyc++;
                if (first_req < 0) begin
                    first_req = c; cap_addr = reg_addr; cap_wr = reg_wr; cap_wd = reg_wdata;
                end
            end
            if (mib_slave_ack) begin
                ack_cnt++;
                if (ack_c < 0) begin ack_c = c; rd_hi = mib_ad_o; end
            end
            if (ack_c > 0 && c == ack_c + 1) rd_lo = mib_ad_o;
            if (mib_ad_oe) begin oe_cnt++; if (first_oe < 0) first_oe = c; end
            if (timeout_pulse) to_cnt++;
            if (proto_err) pe_cnt++;

            reg_ack = 1'b0;
            if (reg_req && req_cyc == dly + 1) begin
                reg_ack = 1'b1;
                if (reg_wr) rf_mem[reg_addr] = reg_wdata;
                else reg_rdata = rf_mem.exists(reg_addr) ? rf_mem[reg_addr] : dflt(reg_addr);
            end else if (!reg_req && !fast && $urandom_range(0, 3) == 0) begin
                reg_ack   = 1'b1;
                reg_rdata = $urandom;
            end
            if (is_wr && c <= 2) begin
                if (mib_ad_oe) cont++;
                mib_ad_i = (c == 1) ? wd[31:16] : wd[15:0];
            end else begin
                mib_ad_i = 16'($urandom);
            end
            @(negedge clk);
            if (fast && ack_c > 0 && c >= ack_c + (is_wr ? 0 : 1)) done = 1'b1;
        end
        reg_ack = 1'b0;

        if (ack_c < 0) $display("master: %s TIMEOUT addr 0x%06h", is_wr ? "WRITE" : "READ", a);
        if (is_wr && !to) model_mem[a] = wd;

        chk("req_cycles", 64'(req_cyc), 64'(to ? TO : dly + 1));
        chk("req_first", 64'(first_req), 64'(is_wr ? 3 : 1));
        chk("req_addr", 64'(cap_addr), 64'(a));
        chk("req_wr", 64'(cap_wr), 64'(is_wr));
        chk("ack_count", 64'(ack_cnt), 64'(to ? 0 : 1));
        chk("ack_cycle", 64'(ack_c), 64'(exp_ack_c));
        chk("timeout_pulses", 64'(to_cnt), 64'(to ? 1 : 0));
        chk("proto_err", 64'(pe_cnt), 64'(exp_perr));
        chk("bus_contention", 64'(cont), 64'd0);
        if (is_wr) begin
            chk("req_wdata", 64'(cap_wd), 64'(wd));
            chk("oe_cycles_wr", 64'(oe_cnt), 64'd0);
        end else begin
            chk("oe_cycles_rd", 64'(oe_cnt), 64'(to ? 0 : 2));
            chk("oe_first", 64'(first_oe), 64'(exp_ack_c));
            if (!to) chk("rdata", 64'({rd_hi, rd_lo}), 64'(exp_rd));
        end
    endtask

    // Start a write and leave it sitting in the first data beat.
    task automatic abort_wr(input logic [23:0] a);
        int rq = 0;
        mib_start = 1'b1; mib_rd_wr_n = 1'b0; mib_ad_i = {8'h00, a[23:16]};
        @(negedge clk);
        if (reg_req) rq++;
        mib_start = 1'b0; mib_ad_i = a[15:0];
        @(negedge clk);
        if (reg_req) rq++;
        chk("abort_no_req", 64'(rq), 64'd0);
    endtask

    task automatic reset_in_rd_hi(input logic [23:0] a);
        int c = 0;
        mib_start = 1'b1; mib_rd_wr_n = 1'b1; mib_ad_i = {8'h00, a[23:16]};
        @(negedge clk);
        mib_start = 1'b0; mib_ad_i = a[15:0];
        @(negedge clk);
        while (!mib_slave_ack && c < WIN) begin
            reg_ack   = reg_req;
            reg_rdata = 32'h0BAD_F00D;
            @(negedge clk);
            c++;
        end
        reg_ack = 1'b0;
        chk("rdhi_oe_before_reset", 64'(mib_ad_oe), 64'd1);
        #1 rst_n = 1'b0;
        #1 outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w, f;
        logic [23:0] a;
        int          d;

        rst_n = 1'b0; mib_start = 1'b0; mib_rd_wr_n = 1'b0; mib_ad_i = '0;
        reg_rdata = '0; reg_ack = 1'b0;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        rf_mem[24'h00ABCD]    = 32'hCAFEF00D;
        model_mem[24'h00ABCD] = 32'hCAFEF00D;

        do_txn(1'b1, 24'h123456, 32'hDEADBEEF, 1, 1'b0, 0);
        do_txn(1'b0, 24'h00ABCD, 32'h0, 3, 1'b0, 0);
        do_txn(1'b0, 24'h000321, 32'h0, 40, 1'b0, 0);
        do_txn(1'b1, 24'h000321, 32'h01234567, 0, 1'b0, 0);
        abort_wr(24'h0F0F0F);
        do_txn(1'b1, 24'h345678, 32'hA5A55A5A, 0, 1'b0, 1);
        chk("aborted_write_absent", 64'(rf_mem.exists(24'h0F0F0F)), 64'd0);
        reset_in_rd_hi(24'h00ABCD);
        do_txn(1'b0, 24'h000001, 32'h0, 2, 1'b0, 0);
        do_txn(1'b1, 24'h00BEEF, 32'h11223344, 0, 1'b1, 0);
        do_txn(1'b0, 24'h00BEEF, 32'h0, 0, 1'b1, 0);
        do_txn(1'b0, 24'h123456, 32'h0, TO - 1, 1'b0, 0);
        do_txn(1'b1, 24'h222222, 32'h55AA55AA, TO, 1'b0, 0);
        do_txn(1'b0, 24'h222222, 32'h0, 0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 24'($urandom);
            else a = 24'($urandom_range(0, 7) * 24'h111111);
            if ($urandom_range(0, 7) == 0) d = int'($urandom_range(TO, TO + 4));
            else d = int'($urandom_range(0, TO - 1));
            f = (d < TO) && ($urandom_range(0, 1) == 1);
            do_txn(w, a, $urandom, d, f, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
